// File: rtl/vram_scan_if.sv
// Bus bundle for vram_scan: CPU single-port access, display scan port and legacy full-array view.
// master = CPU/display side, slave = the VRAM.
interface vram_scan_if #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 10,
   parameter int ADDR_W = $clog2(DEPTH)
);
   logic                     write_enable;
   logic                     read_enable;
   logic [ADDR_W-1:0]        address;
   logic [WIDTH-1:0]         data_input;
   logic [WIDTH/8-1:0]       byte_enable;
   logic [WIDTH-1:0]         data_output;
   logic                     read_valid;
   logic                     addr_error;
   logic                     scan_start;
   logic                     scan_loop;
   logic                     scan_ready;
   logic                     scan_valid;
   logic [WIDTH-1:0]         scan_data;
   logic                     scan_last;
   logic                     scan_busy;
   logic [DEPTH*WIDTH-1:0]   parallel_output;

   modport master (
      output write_enable, read_enable, address, data_input, byte_enable,
      output scan_start, scan_loop, scan_ready,
      input  data_output, read_valid, addr_error,
      input  scan_valid, scan_data, scan_last, scan_busy, parallel_output
   );

   modport slave (
      input  write_enable, read_enable, address, data_input, byte_enable,
      input  scan_start, scan_loop, scan_ready,
      output data_output, read_valid, addr_error,
      output scan_valid, scan_data, scan_last, scan_busy, parallel_output
   );
endinterface

// File: rtl/vram_scan.sv
// Flop-based frame VRAM with registered CPU reads, sticky out-of-range flag and a looping scanout engine.
// Define VRAM_BYTE_ENABLE_EN to honour byte_enable on CPU writes (WIDTH must then be a multiple of 8).
module vram_scan #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 10,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   vram_scan_if.slave  bus
);
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

   typedef enum logic {ST_IDLE, ST_SCAN} t_state;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  r_data_output;
   logic              r_read_valid;
   logic              r_addr_error;
   t_state            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_scan_valid;
   logic              r_scan_last;
   logic              r_scan_busy;

   logic              w_in_range;
   logic              w_wr;
   logic              w_rd;
   logic [WIDTH-1:0]  w_bmask;

   assign w_in_range = ({1'b0, bus.address} < LP_DEPTH);
   assign w_wr       = bus.write_enable & w_in_range;
   assign w_rd       = bus.read_enable & ~bus.write_enable;

`ifdef VRAM_BYTE_ENABLE_EN
   generate
      for (genvar gi = 0; gi < WIDTH/8; gi++) begin : g_bmask
         assign w_bmask[gi*8 +: 8] = {8{bus.byte_enable[gi]}};
      end
   endgenerate
`else
   logic w_unused_be;
   assign w_bmask     = '1;
   assign w_unused_be = ^bus.byte_enable;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[bus.address] <= (r_mem[bus.address] & ~w_bmask) | (bus.data_input & w_bmask);
      end
   end

   // A write wins over a simultaneous read; out-of-range reads still pulse valid with zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_output <= '0;
         r_read_valid  <= 1'b0;
         r_addr_error  <= 1'b0;
      end else begin
         r_read_valid <= w_rd;
         if (w_rd) r_data_output <= w_in_range ? r_mem[bus.address] : '0;
         if ((bus.write_enable | bus.read_enable) & ~w_in_range) r_addr_error <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_scan_valid <= 1'b0;
         r_scan_last  <= 1'b0;
         r_scan_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.scan_start) begin
                  r_state      <= ST_SCAN;
                  r_ptr        <= '0;
                  r_scan_valid <= 1'b1;
                  r_scan_busy  <= 1'b1;
                  r_scan_last  <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (bus.scan_ready) begin
                  if (r_scan_last) begin
                     r_ptr       <= '0;
                     r_scan_last <= 1'b0;
                     if (!bus.scan_loop) begin
                        r_state      <= ST_IDLE;
                        r_scan_valid <= 1'b0;
                        r_scan_busy  <= 1'b0;
                     end
                  end else begin
                     r_ptr       <= r_ptr + 1'b1;
                     r_scan_last <= ((r_ptr + 1'b1) == LP_LAST);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // scan_data follows the live array so a CPU write to the presented word shows up next cycle.
   assign bus.scan_data   = r_scan_valid ? r_mem[r_ptr] : '0;
   assign bus.scan_valid  = r_scan_valid;
   assign bus.scan_last   = r_scan_last;
   assign bus.scan_busy   = r_scan_busy;
   assign bus.data_output = r_data_output;
   assign bus.read_valid  = r_read_valid;
   assign bus.addr_error  = r_addr_error;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_par
         assign bus.parallel_output[gi*WIDTH +: WIDTH] = r_mem[gi];
      end
   endgenerate
endmodule

// File: tb/tb_vram_scan.sv
// Directed bench for vram_scan: reference model checked every cycle plus literal expectations.
module tb_vram_scan;
   localparam int WIDTH = 32;
   localparam int DEPTH = 10;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   bit   chk_en   = 0;

   vram_scan_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
   vram_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_dout;
   bit          m_rvalid, m_err, m_busy;
   int          m_idx;

   logic [31:0] got_q[$];
   bit          last_q[$];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] be);
      logic [31:0] r;
      r = din;
`ifdef VRAM_BYTE_ENABLE_EN
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = din[b*8 +: 8];
`else
      if (be == 4'hx) r = old;
`endif
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      int a;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_dout = '0; m_rvalid = 0; m_err = 0; m_busy = 0; m_idx = 0;
      end else begin
         if (m_busy) begin
            if (bus.scan_ready) begin
               if (m_idx == DEPTH-1) begin
                  m_idx = 0;
                  if (!bus.scan_loop) m_busy = 0;
               end else m_idx++;
            end
         end else if (bus.scan_start) begin
            m_busy = 1; m_idx = 0;
         end
         a = int'(bus.address);
         m_rvalid = 0;
         if ((bus.write_enable || bus.read_enable) && a >= DEPTH) m_err = 1;
         if (bus.write_enable) begin
            if (a < DEPTH) m_mem[a] = merge(m_mem[a], bus.data_input, bus.byte_enable);
         end else if (bus.read_enable) begin
            m_rvalid = 1;
            m_dout   = (a < DEPTH) ? m_mem[a] : '0;
         end
      end
   end

   // transfer recorder sees pre-edge values
   always @(posedge clk) begin
      if (!rst && bus.scan_valid && bus.scan_ready) begin
         got_q.push_back(bus.scan_data);
         last_q.push_back(bus.scan_last);
         $display("scan xfer data=%0h last=%0b", bus.scan_data, bus.scan_last);
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("data_output", bus.data_output, m_dout);
         chk("read_valid",  bus.read_valid,  m_rvalid);
         chk("addr_error",  bus.addr_error,  m_err);
         chk("scan_valid",  bus.scan_valid,  m_busy);
         chk("scan_busy",   bus.scan_busy,   m_busy);
         chk("scan_data",   bus.scan_data,   m_busy ? m_mem[m_idx] : 32'h0);
         chk("scan_last",   bus.scan_last,   m_busy && (m_idx == DEPTH-1));
         for (int i = 0; i < DEPTH; i++)
            chk("parallel", bus.parallel_output[i*WIDTH +: WIDTH], m_mem[i]);
      end
   end

   task automatic drive(input logic we, input logic re, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic st, input logic rdy, input logic lp);
      bus.write_enable = we;
      bus.read_enable  = re;
      bus.address      = a;
      bus.data_input   = d;
      bus.byte_enable  = be;
      bus.scan_start   = st;
      bus.scan_ready   = rdy;
      bus.scan_loop    = lp;
      if (we || re) $display("cpu we=%0b re=%0b addr=%0d data=%0h be=%0h", we, re, a, d, be);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] be_exp;
      bit done;
      rst = 1'b1;
      bus.write_enable = 0; bus.read_enable = 0; bus.address = '0; bus.data_input = '0;
      bus.byte_enable = '0; bus.scan_start = 0; bus.scan_ready = 0; bus.scan_loop = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1;
      chk("rst_dout", bus.data_output, 32'h0);
      chk("rst_err",  bus.addr_error, 1'b0);
      chk("rst_busy", bus.scan_busy, 1'b0);
      chk("rst_par",  bus.parallel_output[3*WIDTH +: WIDTH], 32'h0);

      // write then read back
      drive(1, 0, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      drive(0, 1, 3, 0, 4'hF, 0, 0, 0);
      chk("rd_valid", bus.read_valid, 1'b1);
      chk("rd_data",  bus.data_output, 32'hDEADBEEF);
      chk("rd_par3",  bus.parallel_output[3*WIDTH +: WIDTH], 32'hDEADBEEF);
      drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
      chk("rd_pulse", bus.read_valid, 1'b0);

      // simultaneous write and read: read dropped
      drive(1, 1, 2, 32'h77, 4'hF, 0, 0, 0);
      chk("wr_rd_valid", bus.read_valid, 1'b0);
      chk("wr_rd_par2",  bus.parallel_output[2*WIDTH +: WIDTH], 32'h77);
      chk("wr_rd_dout",  bus.data_output, 32'hDEADBEEF);

      // out of range
      drive(1, 0, 12, 32'h1234, 4'hF, 0, 0, 0);
      chk("oor_err", bus.addr_error, 1'b1);
      drive(0, 1, 12, 0, 4'hF, 0, 0, 0);
      chk("oor_valid", bus.read_valid, 1'b1);
      chk("oor_data",  bus.data_output, 32'h0);
      chk("oor_par3",  bus.parallel_output[3*WIDTH +: WIDTH], 32'hDEADBEEF);

      // byte enable
`ifdef VRAM_BYTE_ENABLE_EN
      be_exp = 32'h11BB33DD;
`else
      be_exp = 32'hAABBCCDD;
`endif
      drive(1, 0, 4, 32'h11223344, 4'hF, 0, 0, 0);
      drive(1, 0, 4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      chk("be_par4", bus.parallel_output[4*WIDTH +: WIDTH], be_exp);
      drive(0, 1, 4, 0, 4'hF, 0, 0, 0);
      chk("be_read", bus.data_output, be_exp);

      // full scan with back-pressure
      for (int i = 0; i < DEPTH; i++) drive(1, 0, 4'(i), 32'(i+1), 4'hF, 0, 0, 0);
      got_q.delete(); last_q.delete();
      drive(0, 0, 0, 0, 4'hF, 1, 0, 0);
      chk("scan_busy_rise", bus.scan_busy, 1'b1);
      for (int c = 0; c < 40 && !(got_q.size() == DEPTH && !bus.scan_busy); c++)
         drive(0, 0, 0, 0, 4'hF, 0, (c % 2 == 0), 0);
      done = (got_q.size() == DEPTH) && !bus.scan_busy;
      chk("scan_done", done, 1'b1);
      chk("scan_count", got_q.size(), DEPTH);
      if (got_q.size() == DEPTH)
         for (int k = 0; k < DEPTH; k++) begin
            chk("scan_word", got_q[k], 32'(k+1));
            chk("scan_lastflag", last_q[k], k == DEPTH-1);
         end
      drive(0, 0, 0, 0, 4'hF, 0, 1, 0);
      chk("scan_idle", bus.scan_valid, 1'b0);

      // looping scan with collision on word 0
      got_q.delete(); last_q.delete();
      drive(0, 0, 0, 0, 4'hF, 1, 1, 1);
      drive(1, 0, 0, 32'h55, 4'hF, 0, 1, 1);
      for (int c = 0; c < 14; c++) drive(0, 0, 0, 0, 4'hF, 0, 1, 1);
      chk("loop_count", got_q.size(), 15);
      if (got_q.size() == 15) begin
         chk("loop_first", got_q[0], 32'h1);
         chk("loop_word9", got_q[9], 32'hA);
         chk("loop_wrap",  got_q[10], 32'h55);
         chk("loop_next",  got_q[11], 32'h2);
      end
      chk("loop_ptr5", bus.scan_data, 32'h6);
      drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
      chk("hold_ptr5", bus.scan_data, 32'h6);

      // asynchronous reset mid-scan
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", bus.scan_valid, 1'b0);
      chk("arst_busy",  bus.scan_busy, 1'b0);
      chk("arst_data",  bus.scan_data, 32'h0);
      chk("arst_par5",  bus.parallel_output[5*WIDTH +: WIDTH], 32'h0);
      chk("arst_err",   bus.addr_error, 1'b0);
      bus.scan_loop = 0; bus.scan_ready = 0;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 5, 0, 4'hF, 0, 0, 0);
      chk("post_rst_read", bus.data_output, 32'h0);
      chk("post_rst_valid", bus.read_valid, 1'b1);
      drive(0, 0, 0, 0, 4'h0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vram_scan.md
# vram_scan

Parametrised video RAM holding one frame of display words, written and read by the ARMv4 core through a single-port bus and streamed to the display controller through a valid/ready scan port. This is the next generation of the team's flop-based VRAM. It adds:
- registered reads with a valid pulse,
- out-of-range detection,
- a sequential scanout engine with frame looping.

The full-array parallel output is kept for legacy consumers.

## Interface
Parameters:
- WIDTH, 32, bits per VRAM word
- DEPTH, 10, number of words (≥2)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- write_enable  in  1  CPU write strobe
- read_enable  in  1  CPU read strobe
- address  in  ADDR_W  CPU word address
- data_input  in  WIDTH  CPU write data
- byte_enable  in  WIDTH/8  per-byte write mask (see Configuration)
- data_output  out  WIDTH  registered CPU read data
- read_valid  out  1  one-cycle pulse: data_output updated
- addr_error  out  1  sticky flag: out-of-range access seen
- scan_start  in  1  pulse: begin a frame scan
- scan_loop  in  1  wrap to word 0 after last word instead of stopping
- scan_ready  in  1  display accepts scan_data
- scan_valid  out  1  scan_data is valid
- scan_data  out  WIDTH  current scan word
- scan_last  out  1  scan_data is word DEPTH-1
- scan_busy  out  1  scan engine in SCAN state
- parallel_output  out  DEPTH×WIDTH  whole array, word i at slice i

## Operation
- Storage is DEPTH×WIDTH flops.
- Reset asynchronously clears:
  - all words
  - data_output, read_valid, addr_error
  - scan pointer and all scan outputs
  - FSM state, to IDLE
- CPU write: when write_enable=1 and address<DEPTH, mem[address] takes data_input at the clock edge.
- CPU read: when read_enable=1, write_enable=0 and address<DEPTH:
  - data_output ← mem[address]
  - read_valid=1 for the next cycle
- Simultaneous write_enable and read_enable: the write is performed; the read is dropped and read_valid stays 0.
- Out of range (address≥DEPTH with either enable):
  - no storage change
  - a read returns 0 with read_valid=1
  - addr_error sets and holds until rst
- Scan FSM, IDLE:
  - scan_valid=0, scan_data=0, scan_last=0.
  - scan_start=1 → SCAN with pointer=0.
- Scan FSM, SCAN:
  - scan_valid=1.
  - scan_data=mem[pointer], read combinationally from the current array.
  - scan_last=(pointer==DEPTH-1).
  - A transfer occurs on scan_valid & scan_ready; on a transfer the pointer increments.
  - Transfer with scan_last and scan_loop=0 → IDLE, pointer=0.
  - Transfer with scan_last and scan_loop=1 → stay in SCAN, pointer=0.
  - scan_start is ignored while in SCAN.
- scan_data and scan_last are held stable while scan_valid=1 and scan_ready=0, unless the CPU writes the word being presented; that write is visible from the following cycle.
- parallel_output is a direct view of the array.

## Timing
- Write latency: 1 edge. Data is visible on parallel_output, scan_data and subsequent reads after the edge.
- Read latency: 1 cycle. data_output holds its last value until the next read.
- Read of a word written in the previous cycle returns the new data.
- CPU write to the scanned word in the same cycle as a scan transfer: the display receives the old value (read-before-write).
- scan_busy rises the cycle after scan_start. It falls the cycle after the final transfer when scan_loop=0.
- Maximum scan throughput: one word per cycle with scan_ready held high. A full frame takes DEPTH cycles.
- rst asserted mid-scan: the scan aborts immediately to IDLE with all outputs zero. Memory is cleared.

## Configuration
- VRAM_BYTE_ENABLE_EN defined:
  - Writes update only bytes whose byte_enable bit is 1.
  - WIDTH must be a multiple of 8.
- VRAM_BYTE_ENABLE_EN undefined:
  - byte_enable is ignored; every write updates the full word.
  - The port remains present, to keep one instantiation.

## Test plan
- Reset and write/read:
  - Stimulus: rst; write 0xDEADBEEF to address 3; read address 3.
  - Response: read_valid pulses one cycle later with data_output=0xDEADBEEF; parallel_output slice 3 = 0xDEADBEEF.
- Out of range:
  - Stimulus: write then read at address 12 with DEPTH=10.
  - Response: storage unchanged; data_output=0 with read_valid=1; addr_error=1 until rst.
- Full scan with back-pressure:
  - Stimulus: words preloaded with i+1; scan_start; scan_ready toggled 1,0,1,…
  - Response: exactly ten transfers carrying 1..10; scan_last only on value 10; then IDLE, scan_busy=0.
- Loop and collision:
  - Stimulus: scan_loop=1, scan_ready=1; CPU writes 0x55 to word 0 in the cycle word 0 is transferred.
  - Response: first pass delivers the old value; second pass delivers 0x55; no gap at wrap.
- Byte enable (macro on):
  - Stimulus: word=0x11223344; write 0xAABBCCDD with byte_enable=4'b0101.
  - Response: word becomes 0x11BB33DD.
  - Macro off: same stimulus gives 0xAABBCCDD.
- Reset mid-scan:
  - Stimulus: assert rst asynchronously at pointer 5.
  - Response: scan_valid, scan_busy and scan_data go to 0 immediately.
